decoder_link_arbiter: RTL and testbench
=======================================

DECODER_LINK_ARBITER -- requirements
Module: decoder_link_arbiter

Interface
REQ-001 Parameter: CODE_DISTANCE, default 5, surface-code distance.
REQ-002 Parameter: REQUESTER_COUNT, default 4, number of message sources sharing the link (2..16).
REQ-003 Parameter: ADDRESS_WIDTH, default 3*$clog2(CODE_DISTANCE) = 9, root address width.
REQ-004 Parameter: DATA_WIDTH, default 2*ADDRESS_WIDTH+2 = 20, link word width, formatted {old_root, updated_root, flag1, flag0}.
REQ-005 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port: reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-007 Port: enable  input  1  arbitration permitted, driven by the stage controller during merging stages.
REQ-008 Port: req_data  input  REQUESTER_COUNT*DATA_WIDTH  requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port: req_valid  input  REQUESTER_COUNT  per-requester word valid.
REQ-010 Port: req_ready  output  REQUESTER_COUNT  per-requester accept, at most one bit high.
REQ-011 Port: out_data  output  DATA_WIDTH  head word toward the stage-controller FIFO link.
REQ-012 Port: out_valid  output  1  head word valid.
REQ-013 Port: out_ready  input  1  link accepts the head word.
REQ-014 Port: busy  output  1  messages in flight, feeding has_message_flying.

Function
REQ-015 The block SHALL contain a 2-entry output FIFO; out_valid = (count != 0) and out_data = head entry, both driven from registers.
REQ-016 A push SHALL occur when some req_valid[i] & req_ready[i] is high; a pop SHALL occur when out_valid & out_ready is high.
REQ-017 A push and a pop in the same cycle SHALL be legal at any count, including count==2; count is unchanged and FIFO order is preserved.
REQ-018 Slot availability SHALL be (count < 2) or (count == 2 and a pop occurs this cycle).
REQ-019 FSM states: IDLE, RUN, DRAIN. IDLE->RUN when enable=1. RUN->DRAIN when enable=0 and count!=0. RUN->IDLE when enable=0 and count==0. DRAIN->IDLE when count reaches 0. DRAIN->RUN when enable=1.
REQ-020 req_ready SHALL be combinational and non-zero only in state RUN with enable=1 and a slot available.
REQ-021 Round-robin: the block SHALL grant the lowest index j, searching from pointer upward modulo REQUESTER_COUNT, with req_valid[j]=1.
REQ-022 After an accepted transfer from requester j, pointer SHALL become (j+1) mod REQUESTER_COUNT; otherwise pointer holds.
REQ-023 Latency: a word accepted into an empty FIFO SHALL appear on out_data with out_valid=1 on the next cycle.
REQ-024 busy SHALL be combinational: (|req_valid) | (count != 0).
REQ-025 In DRAIN and IDLE, pops SHALL continue while out_ready=1, and no requester is granted.

Reset
REQ-026 On reset==0 at a clock edge, the block SHALL set state=IDLE, count=0, pointer=0, out_valid=0, out_data=0, and (if compiled) both counters=0.
REQ-027 Reset mid-operation SHALL discard buffered words with no pop signalled; req_ready SHALL be all-zero while reset==0.

Configuration
REQ-028 Macro LINK_ARBITER_STATS_EN: when defined, the block SHALL add outputs grant_count (32) and stall_count (32).
REQ-029 grant_count SHALL increment on each push; stall_count SHALL increment each cycle with out_valid=1 and out_ready=0. Both counters SHALL wrap at 2^32.
REQ-030 With LINK_ARBITER_STATS_EN undefined, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-031 Reset then enable=1, req_valid=4'b0001, out_ready=1 -> req_ready=4'b0001; the word appears on out_data one cycle later; busy falls after the pop.
REQ-032 req_valid=4'b1111 held, out_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles.
REQ-033 out_ready=0, req_valid=4'b0011 -> two pushes (req 0, then req 1), then req_ready=0 with count=2; raising out_ready pops req 0's word while pushing the next word in the same cycle.
REQ-034 enable dropped with count=2 -> state DRAIN, no grants, two pops, then IDLE and out_valid=0.
REQ-035 reset=0 asserted with count=2 -> next cycle out_valid=0, pointer=0, req_ready=0.
REQ-036 With LINK_ARBITER_STATS_EN defined, 5 pushes and 3 stalled cycles -> grant_count=5, stall_count=3.

Source files
------------

// File: rtl/decoder_link_arbiter.sv
// Round-robin arbiter merging decoder requester words onto one link through a 2-entry FIFO.
// Optional statistics counters (grant_count, stall_count) are enabled with LINK_ARBITER_STATS_EN.
module decoder_link_arbiter #(
    parameter int CODE_DISTANCE   = 5,
    parameter int REQUESTER_COUNT = 4,
    parameter int ADDRESS_WIDTH   = 3 * $clog2(CODE_DISTANCE),
    parameter int DATA_WIDTH      = 2 * ADDRESS_WIDTH + 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [REQUESTER_COUNT*DATA_WIDTH-1:0] req_data,
    input  logic [REQUESTER_COUNT-1:0]            req_valid,
    output logic [REQUESTER_COUNT-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy
`ifdef LINK_ARBITER_STATS_EN
    ,
    output logic [31:0]                           grant_count,
    output logic [31:0]                           stall_count
`endif
);

    localparam int PTR_W = $clog2(REQUESTER_COUNT);
    localparam logic [PTR_W:0] REQ_CNT = (PTR_W + 1)'(REQUESTER_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_count;
    logic [PTR_W-1:0]        r_ptr;
    logic [DATA_WIDTH-1:0]   r_head;
    logic [DATA_WIDTH-1:0]   r_tail;
    logic                    r_out_valid;

    logic                    w_pop;
    logic                    w_push;
    logic                    w_slot;
    logic                    w_grant_en;
    logic                    w_found;
    logic [PTR_W:0]          w_sum;
    logic [PTR_W-1:0]        w_idx;
    logic [PTR_W-1:0]        w_grant_idx;
    logic [PTR_W-1:0]        w_ptr_next;
    logic [REQUESTER_COUNT-1:0] w_grant;
    logic [DATA_WIDTH-1:0]   w_push_data;
    logic [1:0]              w_count_next;

    assign w_pop      = r_out_valid & out_ready;
    assign w_slot     = (r_count < 2'd2) | ((r_count == 2'd2) & w_pop);
    assign w_grant_en = reset & (r_state == RUN) & enable & w_slot;

    // Search upward from the pointer for the first valid requester, wrapping modulo the count.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < REQUESTER_COUNT; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= REQ_CNT) begin
                w_sum = w_sum - REQ_CNT;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && req_valid[w_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx;
            end
        end
        if (w_grant_en && w_found) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign req_ready   = w_grant;
    assign w_push      = |w_grant;
    assign w_push_data = req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_next  = ({1'b0, w_grant_idx} == REQ_CNT - 1'b1) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 2'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_head;
    assign busy      = (|req_valid) | (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_ptr       <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_out_valid <= 1'b0;
`ifdef LINK_ARBITER_STATS_EN
            grant_count <= '0;
            stall_count <= '0;
`endif
        end else begin
            case (r_state)
                IDLE:    if (enable) r_state <= RUN;
                RUN:     if (!enable) r_state <= (r_count != 2'd0) ? DRAIN : IDLE;
                DRAIN: begin
                    if (enable) begin
                        r_state <= RUN;
                    end else if (w_count_next == 2'd0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != 2'd0);
            if (w_push) begin
                r_ptr <= w_ptr_next;
            end

            // A simultaneous push and pop shifts the tail forward so FIFO order holds even when full.
            if (w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
                r_head <= w_push_data;
            end else if (w_pop && (r_count == 2'd2)) begin
                r_head <= r_tail;
            end
            if (w_push && (((r_count == 2'd1) && !w_pop) || ((r_count == 2'd2) && w_pop))) begin
                r_tail <= w_push_data;
            end

`ifdef LINK_ARBITER_STATS_EN
            if (w_push) begin
                grant_count <= grant_count + 32'd1;
            end
            if (r_out_valid && !out_ready) begin
                stall_count <= stall_count + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_decoder_link_arbiter.sv
// Directed bench for decoder_link_arbiter: per-cycle grant/valid/busy checks plus a scoreboard on out_data.
module tb_decoder_link_arbiter;

    localparam int N  = 4;
    localparam int DW = 20;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
`ifdef LINK_ARBITER_STATS_EN
    logic [31:0]     grant_count;
    logic [31:0]     stall_count;
`endif

    int checks = 0;
    int errors = 0;
    int seq    = 0;
    logic [DW-1:0] expQueue[$];

    decoder_link_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef LINK_ARBITER_STATS_EN
        ,
        .grant_count (grant_count),
        .stall_count (stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, seq, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, checks the combinational and registered outputs at the falling
    // edge, and queues the word the bench expects to be granted this cycle.
    task automatic applyStimulus(input logic rst, input logic en, input logic [N-1:0] rv,
                                 input logic ordy, input logic [N-1:0] expReady,
                                 input logic expValid, input logic expBusy);
        @(posedge clk);
        #1;
        seq++;
        reset     = rst;
        enable    = en;
        req_valid = rv;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'((seq << 4) | i);
        end
        if (!rst) begin
            expQueue.delete();
        end
        @(negedge clk);
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        checkOutput("out_valid", 32'(out_valid), 32'(expValid));
        checkOutput("busy", 32'(busy), 32'(expBusy));
        for (int i = 0; i < N; i++) begin
            if (expReady[i]) begin
                expQueue.push_back(DW'((seq << 4) | i));
            end
        end
    endtask

    // Scoreboard monitor: every pop on the link must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (expQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop step %0d: got 0x%0h, expected no word", seq, out_data);
            end else begin
                checkOutput("out_data", 32'(out_data), 32'(expQueue.pop_front()));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        req_data  = '0;

        // Reset, then a single transfer with one-cycle latency and busy falling after the pop.
        applyStimulus(0, 1, 4'b1111, 1, 4'b0000, 0, 1);
        applyStimulus(1, 1, 4'b0001, 1, 4'b0000, 0, 1);
        applyStimulus(1, 1, 4'b0001, 1, 4'b0001, 0, 1);
        applyStimulus(1, 1, 4'b0000, 1, 4'b0000, 1, 1);
        applyStimulus(1, 1, 4'b0000, 1, 4'b0000, 0, 0);

        // Move pointer to 0, then round-robin order 0,1,2,3,0 with all requesters valid.
        applyStimulus(1, 1, 4'b1000, 1, 4'b1000, 0, 1);
        applyStimulus(1, 1, 4'b1111, 1, 4'b0001, 1, 1);
        applyStimulus(1, 1, 4'b1111, 1, 4'b0010, 1, 1);
        applyStimulus(1, 1, 4'b1111, 1, 4'b0100, 1, 1);
        applyStimulus(1, 1, 4'b1111, 1, 4'b1000, 1, 1);
        applyStimulus(1, 1, 4'b1111, 1, 4'b0001, 1, 1);
        applyStimulus(1, 1, 4'b0000, 1, 4'b0000, 1, 1);

        // Pointer back to 0, fill the FIFO with out_ready low, then push and pop while full.
        applyStimulus(1, 1, 4'b1000, 1, 4'b1000, 0, 1);
        applyStimulus(1, 1, 4'b0000, 1, 4'b0000, 1, 1);
        applyStimulus(1, 1, 4'b0011, 0, 4'b0001, 0, 1);
        applyStimulus(1, 1, 4'b0011, 0, 4'b0010, 1, 1);
        applyStimulus(1, 1, 4'b0011, 0, 4'b0000, 1, 1);
        applyStimulus(1, 1, 4'b0011, 1, 4'b0001, 1, 1);

        // Drop enable while full: drain two words with no grants, then idle.
        applyStimulus(1, 0, 4'b0011, 0, 4'b0000, 1, 1);
        applyStimulus(1, 0, 4'b0011, 1, 4'b0000, 1, 1);
        applyStimulus(1, 0, 4'b0011, 1, 4'b0000, 1, 1);
        applyStimulus(1, 0, 4'b0000, 1, 4'b0000, 0, 0);

        // Refill to two words, then reset mid-operation.
        applyStimulus(1, 1, 4'b0011, 0, 4'b0000, 0, 1);
        applyStimulus(1, 1, 4'b0011, 0, 4'b0010, 0, 1);
        applyStimulus(1, 1, 4'b0011, 0, 4'b0001, 1, 1);
        applyStimulus(1, 1, 4'b0011, 0, 4'b0000, 1, 1);
        applyStimulus(0, 1, 4'b0011, 0, 4'b0000, 1, 1);
        applyStimulus(1, 1, 4'b0011, 1, 4'b0000, 0, 1);
        applyStimulus(1, 1, 4'b0011, 1, 4'b0001, 0, 1);
        applyStimulus(1, 1, 4'b0000, 1, 4'b0000, 1, 1);
        applyStimulus(1, 1, 4'b0000, 1, 4'b0000, 0, 0);

        checkOutput("queue_empty", 32'(expQueue.size()), 32'd0);
`ifdef LINK_ARBITER_STATS_EN
        checkOutput("grant_count", grant_count, 32'd1);
        checkOutput("stall_count", stall_count, 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
